cascade_down_counter: RTL

- Two-stage cascadable down counter and countdown timer; the count-down counterpart of the team's cascaded up-counter pair (THRESH0 → CE chaining).
- Low stage decrements on each tick; on wrap it borrows from the high stage.
- Asserts a one-cycle done pulse when the full count is exhausted.
- Used as a programmable delay/timeout generator driven by a prescaler tick.

---
 rtl/cascade_down_counter.sv | 93 +++++++++
 1 files changed

// File: rtl/cascade_down_counter.sv
// Two-stage cascadable down counter / countdown timer. Low stage borrows from the
// high stage on wrap; a one-cycle done pulse marks the exhausted count.
module cascade_down_counter #(
    parameter int W    = 4,
    parameter int MOD0 = 16,
    parameter int MOD1 = 16
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         tick,
    input  logic [W-1:0] load_q0,
    input  logic [W-1:0] load_q1,
    output logic [W-1:0] q0,
    output logic [W-1:0] q1,
    output logic         b0,
    output logic         b1,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [W-1:0] MAX0 = W'(MOD0 - 1);
    localparam logic [W-1:0] MAX1 = W'(MOD1 - 1);

    state_t       state_q, state_d;
    logic [W-1:0] q0_q, q0_d;
    logic [W-1:0] q1_q, q1_d;
    logic [W-1:0] load0_clamped, load1_clamped;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q0_q    <= '0;
            q1_q    <= '0;
        end else begin
            state_q <= state_d;
            q0_q    <= q0_d;
            q1_q    <= q1_d;
        end
    end

    assign load0_clamped = (load_q0 > MAX0) ? MAX0 : load_q0;
    assign load1_clamped = (load_q1 > MAX1) ? MAX1 : load_q1;

    // Priority abort > start > tick; a start always swallows the same-cycle tick.
    always_comb begin
        state_d = state_q;
        q0_d    = q0_q;
        q1_d    = q1_q;
        if (abort) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = RUN;
            q0_d    = load0_clamped;
            q1_d    = load1_clamped;
        end else begin
            case (state_q)
                RUN: begin
                    if (tick) begin
                        if (q0_q != '0) begin
                            q0_d = q0_q - 1'b1;
                        end else if (q1_q != '0) begin
                            q0_d = MAX0;
                            q1_d = q1_q - 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Borrows are combinational so b1 can drive the tick of a further stage.
    assign b0        = (state_q == RUN) && tick && (q0_q == '0);
    assign b1        = b0 && (q1_q == '0);
    assign q0        = q0_q;
    assign q1        = q1_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

endmodule
